alu_addsub_pipe: RTL and testbench



---
 rtl/alu_addsub_pipe.sv | 199 +++++++++++++++++++
 tb/tb_alu_addsub_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: two-stage pipelined 32-bit adder/subtractor.
// Produces the sum/difference together with the Z/V/N flags and a
// registered copy of operand A for the ALU compare/result-mux stage.
// Both sides use a valid/ready handshake, so a slow consumer can stall it.
//
// Optional build macro: ALU_ADDSUB_SKID_EN
//   defined   -> a one-entry skid register at the input. in_ready comes
//                straight from a flop and has no combinational path from
//                out_ready. Capacity is 3 ops.
//   undefined -> no skid. in_ready is combinational from out_ready.
//                Capacity is 2 ops.
module alu_addsub_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  input  logic        in_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_s,
  output logic [31:0] out_a,
  output logic        out_z,
  output logic        out_v,
  output logic        out_n
);

  // Stage 1 holds the operands. The carry-in always equals the sub bit, so
  // s1_sub_reg also serves as the adder carry-in.
  logic        s1_valid_reg;
  logic [31:0] s1_a_reg;
  logic [31:0] s1_b_reg;     // already conditionally inverted (b')
  logic        s1_sub_reg;
  logic        s1_sign_reg;

  // Stage 2 registers drive the outputs directly.
  logic        out_valid_reg;
  logic [31:0] out_s_reg;
  logic [31:0] out_a_reg;
  logic        out_z_reg;
  logic        out_v_reg;
  logic        out_n_reg;

  // Pipeline advance controls.
  logic s2_load;
  logic s1_adv;
  logic s1_load;

  assign s2_load = ~out_valid_reg | out_ready;
  assign s1_adv  = s1_valid_reg & s2_load;
  assign s1_load = ~s1_valid_reg | s1_adv;

  // Operand source that feeds stage 1. This is either the skid entry or the
  // input port.
  logic        src_valid;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        src_sub;
  logic        src_sign;

`ifdef ALU_ADDSUB_SKID_EN
  logic        skid_valid_reg;
  logic [31:0] skid_a_reg;
  logic [31:0] skid_b_reg;
  logic        skid_sub_reg;
  logic        skid_sign_reg;
  logic        in_fire;

  // While the skid is occupied, in_ready is low. The skid entry is therefore
  // always older than anything on the input port, and it goes first.
  assign in_ready  = ~skid_valid_reg;
  assign in_fire   = in_valid & ~skid_valid_reg;
  assign src_valid = skid_valid_reg | in_valid;
  assign src_a     = skid_valid_reg ? skid_a_reg    : in_a;
  assign src_b     = skid_valid_reg ? skid_b_reg    : in_b;
  assign src_sub   = skid_valid_reg ? skid_sub_reg  : in_sub;
  assign src_sign  = skid_valid_reg ? skid_sign_reg : in_sign;

  // Capture an accepted op that stage 1 cannot take this cycle. Drain the
  // skid as soon as stage 1 loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_reg <= 1'b0;
      skid_a_reg     <= '0;
      skid_b_reg     <= '0;
      skid_sub_reg   <= 1'b0;
      skid_sign_reg  <= 1'b0;
    end else if (skid_valid_reg) begin
      if (s1_load) begin
        skid_valid_reg <= 1'b0;
      end
    end else if (in_fire && !s1_load) begin
      skid_valid_reg <= 1'b1;
      skid_a_reg     <= in_a;
      skid_b_reg     <= in_b;
      skid_sub_reg   <= in_sub;
      skid_sign_reg  <= in_sign;
    end
  end
`else
  assign in_ready  = s1_load;
  assign src_valid = in_valid;
  assign src_a     = in_a;
  assign src_b     = in_b;
  assign src_sub   = in_sub;
  assign src_sign  = in_sign;
`endif

  // b' = sub ? ~b : b. Each bit is XORed with the sub bit.
  logic [31:0] src_b_sel;
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_binv
      assign src_b_sel[gi] = src_b[gi] ^ src_sub;
    end
  endgenerate

  // Stage 1: register the operand set whenever stage 1 is free or advancing.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_sub_reg   <= 1'b0;
      s1_sign_reg  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= src_valid;
      if (src_valid) begin
        s1_a_reg    <= src_a;
        s1_b_reg    <= src_b_sel;
        s1_sub_reg  <= src_sub;
        s1_sign_reg <= src_sign;
      end
    end
  end

  // 33-bit add and flag derivation. The extra bit is the carry out (c32).
  logic [32:0] sum33;
  logic [31:0] s_next;
  logic        c32;
  logic        z_next;
  logic        v_next;
  logic        n_next;
  logic        sv_next;

  assign sum33   = {1'b0, s1_a_reg} + {1'b0, s1_b_reg} + {32'd0, s1_sub_reg};
  assign s_next  = sum33[31:0];
  assign c32     = sum33[32];
  assign z_next  = (s_next == 32'd0);
  assign sv_next = (s1_a_reg[31] == s1_b_reg[31]) & (s_next[31] != s1_a_reg[31]);

  // Select the overflow and negative rules for the signed/unsigned mode.
  always_comb begin
    v_next = 1'b0;
    n_next = 1'b0;
    if (s1_sign_reg) begin
      v_next = sv_next;
      n_next = s_next[31] ^ sv_next;   // true sign of the exact result
    end else if (s1_sub_reg) begin
      v_next = ~c32;                   // borrow
      n_next = ~c32;                   // unsigned A < B
    end else begin
      v_next = c32;
      n_next = 1'b0;
    end
  end

  // Stage 2: load a result (or a bubble) when the output slot is free or
  // draining. Data stays put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_s_reg     <= '0;
      out_a_reg     <= '0;
      out_z_reg     <= 1'b0;
      out_v_reg     <= 1'b0;
      out_n_reg     <= 1'b0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_s_reg <= s_next;
        out_a_reg <= s1_a_reg;
        out_z_reg <= z_next;
        out_v_reg <= v_next;
        out_n_reg <= n_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_s     = out_s_reg;
  assign out_a     = out_a_reg;
  assign out_z     = out_z_reg;
  assign out_v     = out_v_reg;
  assign out_n     = out_n_reg;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// tb_alu_addsub_pipe: self-checking bench for alu_addsub_pipe.
// The reference model computes each result with exact 64-bit arithmetic.
// It derives the flags from the mathematical result of A+B or A-B.
module tb_alu_addsub_pipe;

`ifdef ALU_ADDSUB_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic [31:0] out_a;
  logic        out_z;
  logic        out_v;
  logic        out_n;

  alu_addsub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_a     (out_a),
    .out_z     (out_z),
    .out_v     (out_v),
    .out_n     (out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  logic [66:0] exp_q[$];
  bit          hold_pend = 1'b0;
  logic [66:0] hold_val;

  // Reference result packed as {s, a, z, v, n}.
  function automatic logic [66:0] model(logic [31:0] a, logic [31:0] b,
                                        logic sub, logic sign);
    longint ta, tb, r;
    logic [31:0] s;
    logic z, v, n;
    if (sign) begin
      ta = longint'($signed(a));
      tb = longint'($signed(b));
    end else begin
      ta = longint'({32'd0, a});
      tb = longint'({32'd0, b});
    end
    r = sub ? (ta - tb) : (ta + tb);
    s = r[31:0];
    z = (s == 32'd0);
    if (sign) begin
      v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      n = (r < 0);
    end else if (sub) begin
      v = (r < 0);
      n = (r < 0);
    end else begin
      v = (r > 64'sd4294967295);
      n = 1'b0;
    end
    return {s, a, z, v, n};
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(string tag, logic [66:0] obs, logic [66:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of handshake. At the falling edge, check the output against
  // the expected queue and log any accepted input. Then advance past the
  // rising edge.
  task automatic cycle();
    logic [66:0] obs;
    @(negedge clk);
    obs = {out_s, out_a, out_z, out_v, out_n};
    if (hold_pend) begin
      check("hold_valid", {66'd0, out_valid}, 67'd1);
      check("hold_data", obs, hold_val);
    end
    if (out_valid && out_ready) begin
      check("q_nonempty", {66'd0, exp_q.size() > 0}, 67'd1);
      if (exp_q.size() > 0) check("result", obs, exp_q.pop_front());
      $display("out  s=%h a=%h z=%0b v=%0b n=%0b", out_s, out_a, out_z, out_v, out_n);
    end
    hold_pend = out_valid && !out_ready;
    hold_val  = obs;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_a, in_b, in_sub, in_sign));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  // Drive a single op into an empty pipe and check its 2-cycle latency
  // against hand-computed values.
  task automatic directed(string tag, logic [31:0] a, logic [31:0] b, logic sub,
                          logic sign, logic [31:0] es, logic ez, logic ev, logic en);
    in_a = a; in_b = b; in_sub = sub; in_sign = sign;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {66'd0, in_ready}, 67'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, {66'd0, out_valid}, 67'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_lat2"}, {66'd0, out_valid}, 67'd1);
    check({tag, "_res"}, {out_s, out_a, out_z, out_v, out_n}, {es, a, ez, ev, en});
    $display("dir  %s s=%h a=%h z=%0b v=%0b n=%0b", tag, out_s, out_a, out_z, out_v, out_n);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_a [4];
  logic [31:0] bp_b [4];
  int idx;
  int acc_before;
  int cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {66'd0, out_valid}, 67'd0);
    check("rst_in_ready", {66'd0, in_ready}, 67'd1);
    check("rst_outputs", {out_s, out_a, out_z, out_v, out_n}, 67'd0);
    reset = 1'b0;

    // Directed flag cases.
    directed("ssub_5_7",   32'd5,          32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    directed("sadd_ovf",   32'h7FFF_FFFF,  32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("usub_eq",    32'd3,          32'd3, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    directed("uadd_carry", 32'hFFFF_FFFF,  32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    directed("usub_borrow",32'd1,          32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);

    // Back-pressure: 4 ops offered while the consumer stalls for 5 cycles.
    bp_a = '{32'd10, 32'd20, 32'd30, 32'd40};
    bp_b = '{32'd1, 32'd2, 32'd3, 32'd4};
    n_acc = 0; idx = 0; out_ready = 1'b0;
    in_sub = 1'b0; in_sign = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_a = bp_a[idx]; in_b = bp_b[idx]; end
      acc_before = n_acc;
      cycle();
      if (n_acc != acc_before) idx++;
    end
    check("bp_accepts", 67'(n_acc), 67'(CAP));
    check("bp_in_ready_low", {66'd0, in_ready}, 67'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_a = bp_a[idx]; in_b = bp_b[idx]; end
      acc_before = n_acc;
      cycle();
      if (n_acc != acc_before) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_in", 67'(idx), 67'd4);
    check("bp_drained", 67'(exp_q.size()), 67'd0);

    // Reset with the pipe full. Nothing that was in flight may reappear.
    out_ready = 1'b0;
    repeat (4) begin
      in_valid = 1'b1; in_a = rval(); in_b = rval();
      cycle();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", {66'd0, out_valid}, 67'd0);
    check("midrst_in_ready", {66'd0, in_ready}, 67'd1);
    check("midrst_outputs", {out_s, out_a, out_z, out_v, out_n}, 67'd0);
    reset = 1'b0;
    exp_q.delete();
    hold_pend = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();

    // Random handshake traffic against the reference model.
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_a      = rval();
      in_b      = rval();
      in_sub    = 1'($urandom % 2);
      in_sign   = 1'($urandom % 2);
      cycle();
      cyc++;
    end
    check("rand_budget", {66'd0, n_acc >= 10000}, 67'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cycle();
    check("rand_drained", 67'(exp_q.size()), 67'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
